targ_pred_ctrl: RTL and testbench
=================================

# targ_pred_ctrl

Initiator-side controller for the target predictor. It accepts indirect-jump dispatches, queries the predictor on request port 0, and records the returned candidate targets in a small tag-indexed tracking table. It then launches each candidate as a parallel fetch path, one per handshake. When the jump resolves, it reports which path (if any) was correct and drives the predictor's feedback port with the actual target.

## Interface
Parameters:
- entries, 4: tracking-table depth (power of two); tag width = $clog2(entries)
- max_paths, 3: max candidates stored per entry; must equal the predictor's history depth

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- en  in  1  block enable
- jmp_valid  in  1  indirect jump offered
- jmp_ready  out  1  jump accepted this cycle when both high
- jmp_pc  in  core::addr_t  jump base PC
- jmp_tag  out  tag  entry index allocated to the accepted jump (valid with jmp_ready)
- targ_pred_req  out  core::targ_pred_req_t  query to predictor
- targ_pred_rsp  in  core::targ_pred_rsp_t  same-cycle predictor answer
- path_valid  out  1  candidate path presented
- path_ready  in  1  fetch accepts path
- path_pc / path_tag / path_idx  out  addr_t / tag / $clog2(max_paths)  candidate target, owning entry, candidate index
- res_valid / res_tag / res_targ_pc  in  1 / tag / addr_t  branch resolution
- res_out_valid / res_hit / res_hit_idx  out  1 / 1 / $clog2(max_paths)  registered resolution result
- targ_pred_fb  out  core::targ_pred_fb_t  feedback to predictor

## Operation
- Table entry: alloc bit, base_pc, pred_cnt, pred_pc[max_paths].
- FSM states: IDLE, LAUNCH.
- jmp_ready = en && IDLE && any entry free. The free vector is computed from registered alloc bits only.
- Allocation picks the lowest free index.
- While jmp_valid && jmp_ready: targ_pred_req.valid=1 and base_pc=jmp_pc (combinational); otherwise targ_pred_req = core::targ_pred_req_rst.
- On accept, the entry captures base_pc and the full rsp, and alloc is set.
  - If pred_cnt>0: enter LAUNCH with launch pointer k=0 and launch tag = allocated index.
  - If pred_cnt=0: stay IDLE.
- In LAUNCH:
  - path_valid = en; path_pc = pred_pc[k], path_idx = k, path_tag = launch tag.
  - On path_valid && path_ready, k increments.
  - After the handshake at k = pred_cnt-1, return to IDLE.
  - en=0 forces path_valid=0 and freezes k.
- Resolutions are processed regardless of en.
  - If res_valid and the entry at res_tag is allocated: compare res_targ_pc against pred_pc[0..pred_cnt-1].
    - res_hit = any match; res_hit_idx = lowest matching index (0 on miss).
    - Register results and targ_pred_fb {valid=1, base_pc=entry.base_pc, targ_pc=res_targ_pc}.
    - Clear alloc.
  - If the entry is unallocated: ignored; res_out_valid stays 0 next cycle.
- Resolving the entry currently in LAUNCH aborts the launch and returns to IDLE.
- Same-cycle resolve of entry X and accept: the accept cannot take X, because the free vector is registered. X becomes free next cycle.
- The table is full only when all alloc bits are set; jmp_ready=0 then.

## Timing
- Reset values: FSM IDLE, k=0, all alloc=0, jmp_ready=0, path_valid=0, res_out_valid=0, res_hit=0, res_hit_idx=0, targ_pred_fb=core::targ_pred_fb_rst, targ_pred_req=core::targ_pred_req_rst.
- Reset mid-LAUNCH drops path_valid immediately (asynchronous).
- Jump accepted at edge T: first path_valid visible in cycle T+1. One path per cycle under continuous path_ready.
- path_valid must stay high, with stable pc/idx/tag, until path_ready, unless an abort or en=0 intervenes.
- Resolution sampled at edge T: res_out_valid, res_hit, res_hit_idx and targ_pred_fb.valid pulse for exactly the cycle after T. At most one resolution per cycle, hence one feedback per cycle.

## Structure
- Package core: add targ_pred_entry_t (alloc, base_pc, pred_cnt, pred_pc array). Reuse the existing addr_t, targ_pred_req_t, targ_pred_rsp_t, targ_pred_fb_t and their _rst constants.
- One sub-module, targ_pred_match: combinational; inputs entry + target, outputs hit + lowest index.

## Test plan
- Reset with rst=0: all outputs at reset values. Release; jmp_pc=0x100 with rsp {cnt=2, pc=0x200,0x300} -> jmp_tag=0; path 0x200 idx0, then 0x300 idx1 on consecutive cycles; then IDLE.
- Resolve tag0 with 0x300 -> next cycle res_out_valid=1, res_hit=1, res_hit_idx=1, targ_pred_fb {1, 0x100, 0x300}; entry freed.
- Resolve with 0x400 (miss) -> res_hit=0, res_hit_idx=0, fb targ_pc=0x400. Resolve of an unallocated tag -> no output pulse.
- Four jumps with cnt=0 -> tags 0,1,2,3; fifth is held with jmp_ready=0. Resolve tag2 while the fifth is offered -> fifth accepted the following cycle with tag 2.
- Resolve the launching entry while path_ready=0 on idx0 -> path_valid=0 next cycle, FSM IDLE. en=0 mid-LAUNCH -> path_valid=0, k held, resumes at the same idx.
- Assert rst mid-LAUNCH -> path_valid falls without a clock edge; after release, table empty and jmp_ready=1.

Source files
------------

// File: rtl/targ_pred_ctrl_pkg.sv
// Shared core types for the target predictor and its initiator-side controller.
// Provides addr_t, predictor req/rsp/feedback bundles, the tracking entry and FSM states.
package core;

    typedef logic [31:0] addr_t;

    // Predictor history depth; the controller's max_paths must match it.
    localparam int TP_DEPTH = 3;
    localparam int TP_CNT_W = $clog2(TP_DEPTH + 1);

    typedef struct packed {
        logic  valid;
        addr_t base_pc;
    } targ_pred_req_t;

    typedef struct packed {
        logic [TP_CNT_W-1:0]   cnt;
        addr_t [TP_DEPTH-1:0]  pc;
    } targ_pred_rsp_t;

    typedef struct packed {
        logic  valid;
        addr_t base_pc;
        addr_t targ_pc;
    } targ_pred_fb_t;

    typedef struct packed {
        logic                  alloc;
        addr_t                 base_pc;
        logic [TP_CNT_W-1:0]   pred_cnt;
        addr_t [TP_DEPTH-1:0]  pred_pc;
    } targ_pred_entry_t;

    typedef enum logic {
        IDLE,
        LAUNCH
    } ctrl_state_t;

    localparam targ_pred_req_t targ_pred_req_rst = '0;
    localparam targ_pred_fb_t  targ_pred_fb_rst  = '0;

    // True when launch pointer k is the last stored candidate.
    function automatic logic last_path(
        input logic [TP_CNT_W-1:0] k,
        input logic [TP_CNT_W-1:0] cnt
    );
        return (k + TP_CNT_W'(1)) == cnt;
    endfunction

endpackage

// File: rtl/targ_pred_ctrl_if.sv
// Jump / path / resolution handshake bundle of the target predictor controller.
// slave: controller side; master: core side (dispatch, fetch, branch unit).
interface targ_pred_ctrl_if #(
    parameter int entries   = 4,
    parameter int max_paths = 3
);
    localparam int TAG_W = $clog2(entries);
    localparam int IDX_W = $clog2(max_paths);

    logic             jmp_valid;
    logic             jmp_ready;
    core::addr_t      jmp_pc;
    logic [TAG_W-1:0] jmp_tag;

    logic             path_valid;
    logic             path_ready;
    core::addr_t      path_pc;
    logic [TAG_W-1:0] path_tag;
    logic [IDX_W-1:0] path_idx;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    core::addr_t      res_targ_pc;
    logic             res_out_valid;
    logic             res_hit;
    logic [IDX_W-1:0] res_hit_idx;

    modport slave (
        input  jmp_valid, jmp_pc, path_ready,
        input  res_valid, res_tag, res_targ_pc,
        output jmp_ready, jmp_tag,
        output path_valid, path_pc, path_tag, path_idx,
        output res_out_valid, res_hit, res_hit_idx
    );

    modport master (
        output jmp_valid, jmp_pc, path_ready,
        output res_valid, res_tag, res_targ_pc,
        input  jmp_ready, jmp_tag,
        input  path_valid, path_pc, path_tag, path_idx,
        input  res_out_valid, res_hit, res_hit_idx
    );

endinterface

// File: rtl/targ_pred_ctrl_match.sv
// Compares a resolved target against the valid candidates of one entry.
// Ports: entry, targ in; hit (any match), idx (lowest matching index, 0 on miss) out.
module targ_pred_match
    import core::*;
#(
    parameter int max_paths = 3
) (
    input  targ_pred_entry_t               entry,
    input  addr_t                          targ,
    output logic                           hit,
    output logic [$clog2(max_paths)-1:0]   idx
);
    localparam int IDX_W = $clog2(max_paths);

    // Scan high to low so the lowest matching slot wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = TP_DEPTH - 1; i >= 0; i--) begin
            if (TP_CNT_W'(i) < entry.pred_cnt && entry.pred_pc[i] == targ) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/targ_pred_ctrl.sv
// Initiator-side target predictor controller: allocates tracking entries, launches
// candidate fetch paths and reports resolutions. Ports: clk, rst (async, low), en,
// bus (jump/path/resolution handshakes), targ_pred_req/rsp/fb (predictor ports).
module targ_pred_ctrl
    import core::*;
#(
    parameter int entries   = 4,
    parameter int max_paths = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    targ_pred_ctrl_if.slave bus,
    output targ_pred_req_t  targ_pred_req,
    input  targ_pred_rsp_t  targ_pred_rsp,
    output targ_pred_fb_t   targ_pred_fb
);
    localparam int TAG_W = $clog2(entries);
    localparam int IDX_W = $clog2(max_paths);

    targ_pred_entry_t tbl [entries];
    ctrl_state_t      state, state_nx;
    logic [IDX_W-1:0] k, k_nx;
    logic [TAG_W-1:0] ltag, ltag_nx;

    logic [TAG_W-1:0] free_idx;
    logic             any_free;
    logic             jmp_ready_w, path_valid_w;
    logic             accept, fire, res_ok, abort;
    logic             m_hit;
    logic [IDX_W-1:0] m_idx;
    targ_pred_entry_t cur, res_ent;

    logic             rov_q, hit_q;
    logic [IDX_W-1:0] hidx_q;
    targ_pred_fb_t    fb_q;

    // Free vector from registered alloc bits; a same-cycle resolve frees next cycle.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = entries - 1; i >= 0; i--) begin
            if (!tbl[i].alloc) begin
                any_free = 1'b1;
                free_idx = TAG_W'(i);
            end
        end
    end

    assign cur     = tbl[ltag];
    assign res_ent = tbl[bus.res_tag];

    // rst gate keeps jmp_ready low while reset is held.
    assign jmp_ready_w  = rst && en && state == IDLE && any_free;
    assign path_valid_w = en && state == LAUNCH;

    assign accept = bus.jmp_valid && jmp_ready_w;
    assign fire   = path_valid_w && bus.path_ready;
    assign res_ok = bus.res_valid && res_ent.alloc;
    assign abort  = res_ok && state == LAUNCH && bus.res_tag == ltag;

    assign bus.jmp_ready  = jmp_ready_w;
    assign bus.jmp_tag    = free_idx;
    assign bus.path_valid = path_valid_w;
    assign bus.path_pc    = cur.pred_pc[k];
    assign bus.path_idx   = k;
    assign bus.path_tag   = ltag;

    assign bus.res_out_valid = rov_q;
    assign bus.res_hit       = hit_q;
    assign bus.res_hit_idx   = hidx_q;
    assign targ_pred_fb      = fb_q;

    always_comb begin
        targ_pred_req = targ_pred_req_rst;
        if (accept) begin
            targ_pred_req.valid   = 1'b1;
            targ_pred_req.base_pc = bus.jmp_pc;
        end
    end

    targ_pred_match #(
        .max_paths (max_paths)
    ) u_match (
        .entry (res_ent),
        .targ  (bus.res_targ_pc),
        .hit   (m_hit),
        .idx   (m_idx)
    );

    always_comb begin
        state_nx = state;
        k_nx     = k;
        ltag_nx  = ltag;
        unique case (state)
            IDLE: begin
                if (accept && targ_pred_rsp.cnt != '0) begin
                    state_nx = LAUNCH;
                    k_nx     = '0;
                    ltag_nx  = free_idx;
                end
            end
            LAUNCH: begin
                if (abort) begin
                    state_nx = IDLE;
                    k_nx     = '0;
                end else if (fire) begin
                    if (last_path(TP_CNT_W'(k), cur.pred_cnt)) begin
                        state_nx = IDLE;
                        k_nx     = '0;
                    end else begin
                        k_nx = k + IDX_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            k      <= '0;
            ltag   <= '0;
            for (int i = 0; i < entries; i++) tbl[i] <= '0;
            rov_q  <= 1'b0;
            hit_q  <= 1'b0;
            hidx_q <= '0;
            fb_q   <= targ_pred_fb_rst;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            ltag  <= ltag_nx;
            for (int i = 0; i < entries; i++) begin
                if (accept && free_idx == TAG_W'(i)) begin
                    tbl[i].alloc    <= 1'b1;
                    tbl[i].base_pc  <= bus.jmp_pc;
                    tbl[i].pred_cnt <= targ_pred_rsp.cnt;
                    tbl[i].pred_pc  <= targ_pred_rsp.pc;
                end else if (res_ok && bus.res_tag == TAG_W'(i)) begin
                    tbl[i].alloc <= 1'b0;
                end
            end
            rov_q  <= res_ok;
            hit_q  <= res_ok && m_hit;
            hidx_q <= res_ok ? m_idx : '0;
            if (res_ok) begin
                fb_q.valid   <= 1'b1;
                fb_q.base_pc <= res_ent.base_pc;
                fb_q.targ_pc <= bus.res_targ_pc;
            end else begin
                fb_q <= targ_pred_fb_rst;
            end
        end
    end

endmodule

// File: tb/tb_targ_pred_ctrl.sv
// Scoreboard bench for targ_pred_ctrl: directed scenarios then random traffic.
// A queue-based table model predicts accepts, paths and resolution results.
module tb_targ_pred_ctrl;
    import core::*;

    typedef struct { addr_t pc; int idx; int tag; } path_e;
    typedef struct { int tag; addr_t pc; } acc_e;
    typedef struct { bit hit; int idx; addr_t base; addr_t targ; } res_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    targ_pred_ctrl_if #(.entries(4), .max_paths(3)) bus ();
    targ_pred_req_t req;
    targ_pred_rsp_t rsp;
    targ_pred_fb_t  fb;

    targ_pred_ctrl #(.entries(4), .max_paths(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bus           (bus),
        .targ_pred_req (req),
        .targ_pred_rsp (rsp),
        .targ_pred_fb  (fb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit    m_alloc [4];
    addr_t m_base  [4];
    int    m_cnt   [4];
    addr_t m_pc    [4][3];
    int    m_ltag;
    path_e pend [$];

    acc_e  exp_acc   [$];
    path_e exp_paths [$];
    res_e  exp_res   [$];
    bit    exp_jr = 0;
    bit    exp_pv = 0;
    path_e exp_front;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event, expected none at %0t", nm, $time);
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_alloc[i] = 0;
        pend.delete();
        exp_jr = 0;
        exp_pv = 0;
    endtask

    // One clock of stimulus; the model advances with the same inputs.
    task automatic cycle(input bit i_rst, input bit i_en, input bit i_jv,
                         input addr_t i_pc, input int i_cnt,
                         input addr_t p0, input addr_t p1, input addr_t p2,
                         input bit i_pr, input bit i_rv, input int i_rt,
                         input addr_t i_rtarg);
        int ft;
        addr_t ps [3];
        @(negedge clk);
        rst = i_rst;
        en = i_en;
        bus.jmp_valid = i_jv;
        bus.jmp_pc = i_pc;
        rsp.cnt = 2'(i_cnt);
        rsp.pc[0] = p0;
        rsp.pc[1] = p1;
        rsp.pc[2] = p2;
        bus.path_ready = i_pr;
        bus.res_valid = i_rv;
        bus.res_tag = 2'(i_rt);
        bus.res_targ_pc = i_rtarg;
        if (!i_rst) begin
            m_reset();
            return;
        end
        ps[0] = p0; ps[1] = p1; ps[2] = p2;
        ft = -1;
        for (int i = 3; i >= 0; i--) if (!m_alloc[i]) ft = i;
        exp_jr = i_en && pend.size() == 0 && ft >= 0;
        exp_pv = i_en && pend.size() != 0;
        if (exp_pv) begin
            exp_front = pend[0];
            if (i_pr) exp_paths.push_back(pend.pop_front());
        end
        if (i_rv && m_alloc[i_rt]) begin
            res_e r;
            r.hit = 0; r.idx = 0;
            r.base = m_base[i_rt]; r.targ = i_rtarg;
            for (int j = 0; j < m_cnt[i_rt]; j++) begin
                if (!r.hit && m_pc[i_rt][j] == i_rtarg) begin
                    r.hit = 1; r.idx = j;
                end
            end
            exp_res.push_back(r);
            m_alloc[i_rt] = 0;
            if (pend.size() != 0 && m_ltag == i_rt) pend.delete();
        end
        if (i_jv && exp_jr) begin
            acc_e a;
            a.tag = ft; a.pc = i_pc;
            exp_acc.push_back(a);
            m_alloc[ft] = 1;
            m_base[ft] = i_pc;
            m_cnt[ft] = i_cnt;
            for (int j = 0; j < 3; j++) m_pc[ft][j] = ps[j];
            m_ltag = ft;
            for (int j = 0; j < i_cnt; j++) begin
                path_e p;
                p.pc = ps[j]; p.idx = j; p.tag = ft;
                pend.push_back(p);
            end
        end
    endtask

    task automatic idle(input bit pr);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, pr, 0, 0, 0);
    endtask

    task automatic jump(input addr_t pc, input int cnt, input addr_t p0,
                        input addr_t p1, input addr_t p2, input bit pr);
        cycle(1, 1, 1, pc, cnt, p0, p1, p2, pr, 0, 0, 0);
    endtask

    task automatic resolve(input int tag, input addr_t targ, input bit pr);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, pr, 1, tag, targ);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        #2;
        chk("jmp_ready", 64'(bus.jmp_ready), 64'(exp_jr));
        chk("path_valid", 64'(bus.path_valid), 64'(exp_pv));
        if (bus.path_valid && exp_pv) begin
            chk("path_pc_hold", 64'(bus.path_pc), 64'(exp_front.pc));
            chk("path_idx_hold", 64'(bus.path_idx), 64'(exp_front.idx));
            chk("path_tag_hold", 64'(bus.path_tag), 64'(exp_front.tag));
        end
        if (bus.jmp_valid && bus.jmp_ready) begin
            if (exp_acc.size() == 0) bad("jmp_accept");
            else begin
                acc_e a;
                a = exp_acc.pop_front();
                chk("jmp_tag", 64'(bus.jmp_tag), 64'(a.tag));
                chk("req_valid", 64'(req.valid), 64'd1);
                chk("req_base_pc", 64'(req.base_pc), 64'(a.pc));
            end
        end else begin
            chk("req_idle", 64'(req), 64'(targ_pred_req_rst));
        end
        if (bus.path_valid && bus.path_ready) begin
            if (exp_paths.size() == 0) bad("path_fire");
            else begin
                path_e p;
                p = exp_paths.pop_front();
                chk("path_pc", 64'(bus.path_pc), 64'(p.pc));
                chk("path_idx", 64'(bus.path_idx), 64'(p.idx));
                chk("path_tag", 64'(bus.path_tag), 64'(p.tag));
            end
        end
        if (bus.res_out_valid) begin
            if (exp_res.size() == 0) bad("res_out_valid");
            else begin
                res_e r;
                r = exp_res.pop_front();
                chk("res_hit", 64'(bus.res_hit), 64'(r.hit));
                chk("res_hit_idx", 64'(bus.res_hit_idx), 64'(r.idx));
                chk("fb_valid", 64'(fb.valid), 64'd1);
                chk("fb_base_pc", 64'(fb.base_pc), 64'(r.base));
                chk("fb_targ_pc", 64'(fb.targ_pc), 64'(r.targ));
            end
        end else begin
            chk("res_hit_idle", 64'(bus.res_hit), 64'd0);
            chk("res_idx_idle", 64'(bus.res_hit_idx), 64'd0);
            chk("fb_idle", 64'(fb.valid), 64'd0);
        end
    end

    function automatic addr_t pool(input int n);
        return 32'h200 + 32'h100 * addr_t'($urandom_range(0, n));
    endfunction

    initial begin
        rst = 1'b0;
        en = 1'b1;
        bus.jmp_valid = 1'b1;
        bus.jmp_pc = 32'h100;
        bus.path_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_tag = '0;
        bus.res_targ_pc = '0;
        rsp = '0;

        // reset held with a jump offered
        repeat (3) cycle(0, 1, 1, 32'h100, 2, 32'h200, 32'h300, 0, 1, 0, 0, 0);
        #3;
        chk("rst_jmp_ready", 64'(bus.jmp_ready), 64'd0);
        chk("rst_path_valid", 64'(bus.path_valid), 64'd0);
        chk("rst_res_out_valid", 64'(bus.res_out_valid), 64'd0);
        chk("rst_res_hit", 64'(bus.res_hit), 64'd0);
        chk("rst_res_hit_idx", 64'(bus.res_hit_idx), 64'd0);
        chk("rst_fb", 64'(fb.valid) | 64'(fb.base_pc) | 64'(fb.targ_pc), 64'd0);
        chk("rst_req", 64'(req), 64'(targ_pred_req_rst));

        // basic launch and hit resolution
        jump(32'h100, 2, 32'h200, 32'h300, 0, 1);
        idle(1);
        idle(1);
        idle(1);
        resolve(0, 32'h300, 1);
        idle(1);

        // miss: stale slots beyond cnt must not match; then unallocated tag
        jump(32'h180, 0, 32'h400, 32'h400, 32'h400, 1);
        resolve(0, 32'h400, 1);
        resolve(1, 32'h200, 1);
        idle(1);

        // fill the table, hold a fifth, free tag 2 under it
        jump(32'h1000, 0, 0, 0, 0, 1);
        jump(32'h1004, 0, 0, 0, 0, 1);
        jump(32'h1008, 0, 0, 0, 0, 1);
        jump(32'h100c, 0, 0, 0, 0, 1);
        jump(32'h1010, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 32'h1010, 0, 0, 0, 0, 1, 1, 2, 32'h0);
        jump(32'h1010, 0, 0, 0, 0, 1);
        idle(1);
        for (int t = 0; t < 4; t++) resolve(t, 32'h0, 1);
        idle(1);

        // en=0 mid-launch freezes k
        jump(32'h500, 3, 32'h210, 32'h220, 32'h230, 1);
        idle(1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        idle(1);
        resolve(0, 32'h230, 1);
        idle(1);

        // resolving the launching entry aborts it
        jump(32'h600, 3, 32'h240, 32'h250, 32'h260, 0);
        resolve(0, 32'h999, 0);
        idle(0);
        idle(1);

        // asynchronous reset mid-launch
        jump(32'h700, 3, 32'h270, 32'h280, 32'h290, 0);
        idle(0);
        #3;
        rst = 1'b0;
        m_reset();
        #1;
        chk("async_rst_path_valid", 64'(bus.path_valid), 64'd0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        #1;
        chk("post_rst_jmp_ready", 64'(bus.jmp_ready), 64'd1);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            cycle(1, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                  $urandom, int'($urandom_range(0, 3)),
                  pool(3), pool(3), pool(3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 3)), pool(4));
        end
        repeat (4) idle(1);
        #3;
        chk("acc_left", 64'(exp_acc.size()), 64'd0);
        chk("paths_left", 64'(exp_paths.size()), 64'd0);
        chk("res_left", 64'(exp_res.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
